// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: shared opcode encoding, FSM states and constants for alu_pipe.
//   alu_op_e : 4-bit opcode; 0..7 are defined operations, 8..15 are illegal.
//   NUM_OPS  : number of defined opcodes.
//   state_e  : control FSM states (MUL only reachable with ALU_PIPE_MUL_EN).
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_LE  = 4'd3,
    OP_XOR = 4'd4,
    OP_OR  = 4'd5,
    OP_SLT = 4'd6,
    OP_MUL = 4'd7
  } alu_op_e;

  localparam int NUM_OPS = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation/result handshake bundle for alu_pipe.
//   Input channel : in_valid, in_ready, a, b, opcode.
//   Output channel: out_valid, out_ready, result, err, zero.
//   master modport: the issuing side (drives operations, consumes results).
//   slave  modport: the ALU itself.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;
  logic             zero;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, err, zero
  );

  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, err, zero
  );
endinterface

// File: rtl/alu_pipe_mul.sv
// alu_pipe_mul: iterative shift-add multiplier, one partial product per clock.
//   clk, rst : clock, synchronous active-high reset (aborts any operation).
//   start    : latch a/b and begin; ignored while busy.
//   a, b     : operands.
//   busy     : an operation is in progress.
//   done     : final step this cycle; product is valid while done is high.
//   product  : low WIDTH bits of a*b (combinational, includes the final step).
module alu_pipe_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] ma, mb, acc, acc_nxt;
  logic [CW-1:0]    cnt;

  // ma walks left, mb walks right: bit 0 of mb gates the current partial product.
  assign acc_nxt = acc + (mb[0] ? ma : '0);
  assign done    = busy && (cnt == CW'(WIDTH-1));
  // Exposing acc_nxt lets the caller capture on the last step with no extra cycle.
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      acc  <= '0;
      ma   <= '0;
      mb   <= '0;
    end else if (busy) begin
      acc <= acc_nxt;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= done ? '0 : cnt + CW'(1);
      if (done) busy <= 1'b0;
    end else if (start) begin
      ma   <= a;
      mb   <= b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end
  end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU between operand issue and writeback.
//   clk, rst : clock, synchronous active-high reset.
//   bus      : alu_pipe_if.slave -- valid/ready operation in, valid/ready
//              result out with err (illegal/disabled opcode) and zero flags.
// Single-cycle ops register their result the cycle after transfer and can
// stream one per clock. With ALU_PIPE_MUL_EN defined, opcode 7 runs through
// alu_pipe_mul for WIDTH steps; otherwise opcode 7 is reported as illegal.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_pipe_if.slave bus
);
  state_e           state_q, state_d;
  alu_op_e          op;
  logic             in_ready, in_fire, out_fire;
  logic             is_mul, mul_busy, mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic             vld_q, err_q, zero_q;
  logic [WIDTH-1:0] res_q;

  assign op       = alu_op_e'(bus.opcode);
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = vld_q && bus.out_ready;

`ifdef ALU_PIPE_MUL_EN
  logic mul_start;
  assign is_mul    = (op == OP_MUL);
  assign mul_start = in_fire && is_mul;

  alu_pipe_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.a),
    .b       (bus.b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_busy = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  // Single-cycle decode. OP_MUL lands here only when the multiplier is absent
  // (when present, MUL results come from u_mul and this path is not loaded).
  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (op)
      OP_ADD:  alu_res = bus.a + bus.b;
      OP_SUB:  alu_res = bus.a - bus.b;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_LE:   alu_res = {{(WIDTH-1){1'b0}}, (bus.a <= bus.b)};
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // in_ready depends only on state and out_ready (plus our own registered
  // valid), so the consumer can drain and we accept in the same cycle.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !mul_busy && (!vld_q || bus.out_ready);
        if (bus.in_valid && in_ready && is_mul) state_d = ST_MUL;
      end
      ST_MUL:  if (mul_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A MUL is only accepted when the output slot is free or draining, so the
  // slot is always empty by the time mul_done fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      res_q  <= '0;
      err_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (mul_done) begin
      vld_q  <= 1'b1;
      res_q  <= mul_prod;
      err_q  <= 1'b0;
      zero_q <= (mul_prod == '0);
    end else if (in_fire && !is_mul) begin
      vld_q  <= 1'b1;
      res_q  <= alu_res;
      err_q  <= alu_err;
      zero_q <= (alu_res == '0);
    end else if (out_fire) begin
      vld_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q;
  assign bus.result    = res_q;
  assign bus.err       = err_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed + randomized bench for alu_pipe (WIDTH=16) with a
// transaction-level reference model. Honors ALU_PIPE_MUL_EN like the design.
module tb_alu_pipe;
  localparam int W = 16;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_pipe_if #(.WIDTH(W)) bus();
  alu_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level result of a single-cycle opcode: {err, result}.
  function automatic logic [W:0] ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0] r;
    r = '0;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = {{(W-1){1'b0}}, (a <= b)};
      4'd4: r = a ^ b;
      4'd5: r = a | b;
      4'd6: r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return {1'b1, {W{1'b0}}};
    endcase
    return {1'b0, r};
  endfunction

  // Reference model: an output slot plus a MUL countdown in cycles.
  bit           m_valid  = 1'b0;
  logic [W-1:0] m_res    = '0;
  bit           m_err    = 1'b0;
  int           m_mulcnt = 0;
  logic [W-1:0] m_mulres = '0;

  always @(posedge clk) begin
    bit rdy, inf, outf, ld, nerr;
    logic [W-1:0] nres;
    logic [W:0] o;
    logic [2*W-1:0] prod;
    if (rst) begin
      m_valid  <= 1'b0;
      m_res    <= '0;
      m_err    <= 1'b0;
      m_mulcnt <= 0;
    end else begin
      rdy  = (m_mulcnt == 0) && (!m_valid || bus.out_ready);
      inf  = bus.in_valid && rdy;
      outf = m_valid && bus.out_ready;
      ld   = 1'b0;
      nres = m_res;
      nerr = m_err;
      if (m_mulcnt > 0) begin
        m_mulcnt <= m_mulcnt - 1;
        if (m_mulcnt == 1) begin ld = 1'b1; nres = m_mulres; nerr = 1'b0; end
      end else if (inf) begin
        if (MUL_EN && bus.opcode == 4'd7) begin
          prod     = bus.a * bus.b;
          m_mulres <= prod[W-1:0];
          m_mulcnt <= W;
        end else begin
          o = ref_op(bus.opcode, bus.a, bus.b);
          ld = 1'b1; nerr = o[W]; nres = o[W-1:0];
        end
      end
      m_res   <= nres;
      m_err   <= nerr;
      m_valid <= ld ? 1'b1 : (outf ? 1'b0 : m_valid);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", bus.in_ready, (m_mulcnt == 0) && (!m_valid || bus.out_ready));
      chk("out_valid", bus.out_valid, m_valid);
      if (m_valid) begin
        chk("result", bus.result, m_res);
        chk("err", bus.err, m_err);
        chk("zero", bus.zero, m_res == '0);
      end
    end
  end

  // Issue one op with out_ready high; busy = cycles the op occupies the block.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int busy, input logic [W-1:0] er, input bit ee, input bit ez);
    bus.in_valid = 1'b1; bus.opcode = op; bus.a = a; bus.b = b; bus.out_ready = 1'b1;
    @(negedge clk); chk("lit_accept", bus.in_ready, 1'b1);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    for (int i = 0; i < busy; i++) begin
      @(negedge clk);
      chk("lit_busy_valid", bus.out_valid, 1'b0);
      chk("lit_busy_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("lit_valid", bus.out_valid, 1'b1);
    chk("lit_result", bus.result, er);
    chk("lit_err", bus.err, ee);
    chk("lit_zero", bus.zero, ez);
    chk("lit_model", m_res, er);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.opcode = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, '0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_zero", bus.zero, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    do_op(4'd3, 16'h0005, 16'h0005, 0, 16'h0001, 1'b0, 1'b0);  // LE
    do_op(4'd4, 16'hA5A5, 16'hA5A5, 0, 16'h0000, 1'b0, 1'b1);  // XOR
    do_op(4'd0, 16'hFFFF, 16'h0001, 0, 16'h0000, 1'b0, 1'b1);  // ADD wraps
    do_op(4'd6, 16'h8000, 16'h0001, 0, 16'h0001, 1'b0, 1'b0);  // SLT signed
    do_op(4'd1, 16'h0000, 16'h0001, 0, 16'hFFFF, 1'b0, 1'b0);  // SUB wraps
    do_op(4'd12, 16'h1234, 16'h5678, 0, 16'h0000, 1'b1, 1'b1); // illegal
`ifdef ALU_PIPE_MUL_EN
    do_op(4'd7, 16'h0123, 16'h0045, W, 16'h4E6F, 1'b0, 1'b0);
`else
    do_op(4'd7, 16'h0123, 16'h0045, 0, 16'h0000, 1'b1, 1'b1);
`endif

    // Ten back-to-back single-cycle ops.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.opcode = 4'($urandom_range(0, 6));
      bus.a = 16'($urandom); bus.b = 16'($urandom); bus.out_ready = 1'b1;
      @(negedge clk); chk("burst_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      @(negedge clk); if (bus.out_valid) n++;
    end
    chk("burst_count", 16'(n), 16'd10);
    #1 bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: result held 5 cycles, then drain + accept together.
    bus.in_valid = 1'b1; bus.opcode = 4'd0; bus.a = 16'h0001; bus.b = 16'h0002;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.opcode = 4'd5; bus.a = 16'h00F0; bus.b = 16'h000F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_ready", bus.in_ready, 1'b0);
      chk("hold_result", bus.result, 16'h0003);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk); chk("drain_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("swap_valid", bus.out_valid, 1'b1);
    chk("swap_result", bus.result, 16'h00FF);
    @(posedge clk); #1;

`ifdef ALU_PIPE_MUL_EN
    // Reset in the middle of a MUL: nothing comes out, block is idle.
    bus.in_valid = 1'b1; bus.opcode = 4'd7; bus.a = 16'h0003; bus.b = 16'h0007;
    @(posedge clk); #1; bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      chk("abort_valid", bus.out_valid, 1'b0);
      chk("abort_ready", bus.in_ready, 1'b1);
    end
    @(posedge clk); #1;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.opcode    = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       begin bus.a = 16'($urandom); bus.b = bus.a; end
        1:       begin bus.a = '0; bus.b = 16'($urandom); end
        default: begin bus.a = 16'($urandom); bus.b = 16'($urandom); end
      endcase
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (W + 3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 16-bit LE/XOR ALU. Accepts one operation per transfer on a valid/ready input channel and returns a registered result, with error and zero flags, on a valid/ready output channel. Single-cycle ops sustain one result per clock. An optional iterative multiplier runs for WIDTH cycles per operation. It sits between the operand-issue logic and the writeback stage of the datapath.

## Interface
- WIDTH, 16: operand/result width in bits; ≥ 2.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opcode  in  4  operation select.
- out_valid  out  1  result presented.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- err  out  1  illegal or disabled opcode; qualified by out_valid.
- zero  out  1  result == 0; qualified by out_valid.

## Operation
- Opcodes, numeric values:
  - 0 ADD: a+b, modulo 2^WIDTH.
  - 1 SUB: a−b, modulo 2^WIDTH.
  - 2 AND.
  - 3 LE: unsigned a≤b, zero-extended to WIDTH.
  - 4 XOR.
  - 5 OR.
  - 6 SLT: signed a<b, zero-extended to WIDTH.
  - 7 MUL: low WIDTH bits of the unsigned product.
- Opcodes 8–15: result=0, err=1.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- FSM states:
  - IDLE: in_ready = !out_valid || out_ready.
    - Non-MUL transfer: result, err and zero load next cycle, out_valid=1, state stays IDLE.
    - MUL transfer: latch a and b, clear the accumulator, count=0, go to MUL.
  - MUL: in_ready=0. One shift-add step per cycle; count increments.
    - At count==WIDTH−1: load result and flags, set out_valid, go to IDLE.
- out_valid clears on an output transfer with no new result loading that cycle.
- While out_valid && !out_ready, result, err and zero are held stable.
- A back-to-back accept and drain in the same cycle is legal: the new result replaces the drained one with no bubble.
- The input side never drops an accepted operation. The output side never loses an unconsumed result.

## Timing
- Reset values: out_valid=0, result=0, err=0, zero=0, state=IDLE, count=0. in_ready=1 in the first cycle after reset deasserts.
- Reset mid-MUL aborts the operation; no output is produced.
- Latency, non-MUL: 1 cycle from the input transfer to out_valid.
- Latency, MUL: WIDTH cycles from the input transfer to out_valid.
- Throughput: 1 op per cycle for non-MUL ops; 1 per WIDTH cycles for MUL.
- in_ready is combinational from out_ready and state. No other combinational input-to-output paths exist.

## Configuration
- ALU_PIPE_MUL_EN defined: the MUL path, MUL state and counter are present; opcode 7 behaves as above.
- ALU_PIPE_MUL_EN undefined: the multiplier logic is removed. Opcode 7 is treated as illegal: 1-cycle latency, result=0, err=1. The FSM never leaves IDLE.

## Structure
- Package alu_pipe_pkg holds:
  - typedef enum logic [3:0] alu_op_e, with the opcode values above.
  - Localparam NUM_OPS=8.
- Sub-module alu_pipe_mul: iterative shift-add multiplier.
  - Ports: start, a, b, busy, done, product.
  - Instantiated only under ALU_PIPE_MUL_EN.
- Single-cycle ops are decoded in one always_comb inside alu_pipe.

## Test plan
- WIDTH=16, a=0x0005, b=0x0005, op LE, out_ready=1 → next cycle out_valid=1, result=0x0001, zero=0, err=0.
- op XOR, a=b=0xA5A5 → result=0x0000, zero=1. ADD 0xFFFF+0x0001 → result 0x0000 (wraps). SLT a=0x8000, b=0x0001 → result 0x0001.
- 10 consecutive non-MUL ops with out_ready held high → 10 results on 10 consecutive cycles, with in_ready constantly 1.
- out_ready=0 for 5 cycles after a result → result stable and in_ready=0 throughout. Raising out_ready drains the held result and accepts the waiting op in the same cycle.
- MUL with ALU_PIPE_MUL_EN, a=0x0123, b=0x0045 → out_valid exactly 16 cycles after the transfer, result=0x4E6F, in_ready=0 meanwhile. Asserting rst mid-MUL → no out_valid, and the block is back in IDLE.
- Opcodes 7 (macro undefined) and 12 → result=0, err=1, latency 1.
